// File: rtl/gray_pkg.sv
// ----------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the gray_counter slice:
//   - DEFAULT_WIDTH : default count width
//   - MAX_WIDTH     : widest count the bin2gray helper handles
//   - state_e       : control FSM states (IDLE / RUN / DONE)
//   - bin2gray()    : binary to reflected Gray code
// ----------------------------------------------------------------------------
package gray_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Operates on the widest supported vector; callers zero-extend their
    // count and truncate the result back to their own width.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

endpackage : gray_pkg

// File: rtl/gray_counter_if.sv
// ----------------------------------------------------------------------------
// gray_counter_if
// Control, load and ready/valid output bundle of gray_counter.
//   en, up, load, load_val, out_ready : driven by the master (consumer side)
//   out_valid, bin_out, gray_out, tc, err : driven by the slave (counter)
// ----------------------------------------------------------------------------
interface gray_counter_if
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             tc;
    logic             err;

    modport master (
        output en, up, load, load_val, out_ready,
        input  out_valid, bin_out, gray_out, tc, err
    );

    modport slave (
        input  en, up, load, load_val, out_ready,
        output out_valid, bin_out, gray_out, tc, err
    );

endinterface : gray_counter_if

// File: rtl/gray2bin.sv
// ----------------------------------------------------------------------------
// gray2bin
// Combinational Gray-to-binary decoder. Bit i of the binary value is the XOR
// of all Gray bits from i up to the MSB (prefix XOR from the top).
//   i_gray : Gray-coded input, WIDTH bits
//   o_bin  : decoded binary value, WIDTH bits
// ----------------------------------------------------------------------------
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // Prefix XOR: each output bit reduces the Gray bits at and above it.
    always_comb begin
        o_bin = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule : gray2bin

// File: rtl/gray_counter.sv
// ----------------------------------------------------------------------------
// gray_counter
// Up/down binary counter with registered Gray-code output, presented to a
// consumer through a ready/valid handshake. The count advances by one step
// per accepted code. WRAP=1 wraps at the ends of range; WRAP=0 parks the
// FSM in DONE when a terminal code is accepted, until the next load.
//
// Parameters
//   WIDTH : count width in bits (>= 2)
//   WRAP  : 1 = wrap-around, 0 = saturate
// Ports
//   clk   : clock, rising edge active
//   rst_n : asynchronous active-low reset
//   bus   : gray_counter_if.slave (en, up, load, load_val, out_ready in;
//           out_valid, bin_out, gray_out, tc, err out)
//
// Optional self-check, enabled by defining GRAY_COUNTER_CHECK_EN:
//   err is set sticky (cleared only by reset) when the decoded gray_out
//   disagrees with bin_out, or when two successively accepted codes not
//   separated by a load differ in other than exactly one bit. Without the
//   macro err is tied low and no checker logic exists.
// ----------------------------------------------------------------------------
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int WRAP  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    gray_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] w_bin_nxt;
    logic [WIDTH-1:0] w_gray_nxt;
    logic [WIDTH-1:0] w_bin_step;
    logic             w_xfer;
    logic             w_tc;
    logic             w_hold;

    assign w_xfer     = (r_state == RUN) && bus.out_ready;
    assign w_tc       = bus.up ? (r_bin == ALL_ONES) : (r_bin == ZERO);
    // In saturating mode an accepted terminal code freezes the count.
    assign w_hold     = (WRAP == 0) && w_tc;
    assign w_bin_step = bus.up ? (r_bin + ONE) : (r_bin - ONE);
    assign w_gray_nxt = WIDTH'(bin2gray(MAX_WIDTH'(w_bin_nxt)));

    // Next-state and next-count decode; load overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        if (bus.load) begin
            // A transfer on this edge is consumed without advancing.
            w_bin_nxt   = bus.load_val;
            w_state_nxt = bus.en ? RUN : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.en) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        if (w_hold) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_bin_nxt   = w_bin_step;
                            w_state_nxt = bus.en ? RUN : IDLE;
                        end
                    end else begin
                        // Presented code is held until accepted, even if en drops.
                        w_state_nxt = RUN;
                    end
                end
                DONE: begin
                    w_state_nxt = DONE;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_bin_nxt   = r_bin;
                end
            endcase
        end
    end

    // State, binary count and Gray code registers; Gray is computed from the
    // next binary value so both update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_bin   <= ZERO;
            r_gray  <= ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_bin   <= w_bin_nxt;
            r_gray  <= w_gray_nxt;
        end
    end

    assign bus.out_valid = (r_state == RUN);
    assign bus.bin_out   = r_bin;
    assign bus.gray_out  = r_gray;
    assign bus.tc        = w_tc;

`ifdef GRAY_COUNTER_CHECK_EN
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] r_last;
    logic             r_last_vld;
    logic             r_err;
    logic             w_dec_bad;
    logic             w_step_bad;
    logic             w_repeat_ok;

    // Decodes the code actually presented on the output, not the internal
    // register, so a corrupted output path is caught too.
    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .i_gray (bus.gray_out),
        .o_bin  (w_dec)
    );

    assign w_step      = bus.gray_out ^ r_last;
    assign w_dec_bad   = (w_dec != r_bin);
    assign w_repeat_ok = (WRAP == 0) && (w_step == ZERO);
    assign w_step_bad  = w_xfer && r_last_vld && !$onehot(w_step) && !w_repeat_ok;

    // Sticky error flag and history of the last accepted code; a load
    // starts a fresh sequence with no predecessor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_last     <= ZERO;
            r_last_vld <= 1'b0;
        end else begin
            r_err <= r_err | w_dec_bad | w_step_bad;
            if (bus.load) begin
                r_last_vld <= 1'b0;
                r_last     <= r_last;
            end else if (w_xfer) begin
                r_last_vld <= 1'b1;
                r_last     <= bus.gray_out;
            end else begin
                r_last_vld <= r_last_vld;
                r_last     <= r_last;
            end
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// ----------------------------------------------------------------------------
// tb_gray_counter
// Drives a wrapping (WRAP=1) and a saturating (WRAP=0) 4-bit gray_counter
// with the same stimulus and compares both against a behavioural model of
// the counting rules, plus directed scenarios with constant expectations.
// ----------------------------------------------------------------------------
module tb_gray_counter;

    logic       clk;
    logic       rst_n;
    logic       tb_en;
    logic       tb_up;
    logic       tb_load;
    logic [3:0] tb_load_val;
    logic       tb_ready;

    int n_vec;
    int n_bad;

    // Model state per instance: index 0 = wrapping, 1 = saturating.
    // m_st: 0 = idle, 1 = presenting a code, 2 = finished
    int m_cnt [2];
    int m_st  [2];
    bit m_err [2];

    logic [3:0] gray_tab [16];

    gray_counter_if #(.WIDTH(4)) if_w ();
    gray_counter_if #(.WIDTH(4)) if_s ();

    assign if_w.en = tb_en;  assign if_w.up = tb_up;  assign if_w.load = tb_load;
    assign if_w.load_val = tb_load_val;  assign if_w.out_ready = tb_ready;
    assign if_s.en = tb_en;  assign if_s.up = tb_up;  assign if_s.load = tb_load;
    assign if_s.load_val = tb_load_val;  assign if_s.out_ready = tb_ready;

    gray_counter #(.WIDTH(4), .WRAP(1)) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_w)
    );

    gray_counter #(.WIDTH(4), .WRAP(0)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_st[k]  = 0;
            m_err[k] = 1'b0;
        end
    endtask

    // One clock edge of the counting rules for instance k.
    task automatic model_step(input int k, input bit wrap);
        bit at_end;
        at_end = tb_up ? (m_cnt[k] == 15) : (m_cnt[k] == 0);
        if (tb_load) begin
            m_cnt[k] = int'(tb_load_val);
            m_st[k]  = tb_en ? 1 : 0;
        end else if (m_st[k] == 0) begin
            if (tb_en) m_st[k] = 1;
        end else if (m_st[k] == 1 && tb_ready) begin
            if (!wrap && at_end) begin
                m_st[k] = 2;
            end else begin
                m_cnt[k] = tb_up ? (m_cnt[k] + 1) % 16 : (m_cnt[k] + 15) % 16;
                m_st[k]  = tb_en ? 1 : 0;
            end
        end
    endtask

    task automatic cmp_inst(input string tag, input int k, input logic v, input logic [3:0] b,
                            input logic [3:0] g, input logic t, input logic e);
        int eg;
        bit et;
        eg = m_cnt[k] ^ (m_cnt[k] / 2);
        et = tb_up ? (m_cnt[k] == 15) : (m_cnt[k] == 0);
        check_val({tag, "/valid"}, 32'(v), 32'(m_st[k] == 1));
        check_val({tag, "/bin"},   32'(b), 32'(m_cnt[k]));
        check_val({tag, "/gray"},  32'(g), 32'(eg));
        check_val({tag, "/tc"},    32'(t), 32'(et));
        check_val({tag, "/err"},   32'(e), 32'(m_err[k]));
    endtask

    task automatic compare_all(input string tag);
        cmp_inst({tag, "/wrap"}, 0, if_w.out_valid, if_w.bin_out, if_w.gray_out, if_w.tc, if_w.err);
        cmp_inst({tag, "/sat"},  1, if_s.out_valid, if_s.bin_out, if_s.gray_out, if_s.tc, if_s.err);
    endtask

    // Apply one rising edge, advance the model, then sample just after it.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [3:0] corrupt;
        n_vec = 0;
        n_bad = 0;
        gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        rst_n = 1'b1;
        tb_en = 1'b0; tb_up = 1'b0; tb_load = 1'b0; tb_load_val = 4'h0; tb_ready = 1'b0;
        model_reset();

        // Reset state, tc decoded with up=0 and up=1 during reset
        #1 rst_n = 1'b0;
        #1 compare_all("rst_dn");
        check_val("rst_tc_dn", 32'(if_w.tc), 32'd1);
        tb_up = 1'b1;
        #1 compare_all("rst_up");
        #5 rst_n = 1'b1;
        tb_en = 1'b1; tb_ready = 1'b1;
        #4 check_val("rel_no_change", 32'(if_w.out_valid), 32'd0);

        // Full up sequence with wrap-around
        for (int i = 0; i < 17; i++) begin
            tick("seq");
            check_val("seq_gray", 32'(if_w.gray_out), 32'(gray_tab[i % 16]));
        end
        check_val("seq_err", 32'(if_w.err), 32'd0);

        // Back-pressure holds the presented code
        tb_load = 1'b1; tb_load_val = 4'd5; tb_ready = 1'b0;
        tick("ld5");
        tb_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("hold");
            check_val("hold_gray",  32'(if_w.gray_out), 32'h7);
            check_val("hold_valid", 32'(if_w.out_valid), 32'd1);
        end
        tb_ready = 1'b1;
        tick("release");
        check_val("release_gray", 32'(if_w.gray_out), 32'h5);
        check_val("release_bin",  32'(if_w.bin_out), 32'h6);

        // Saturation at the top of range, then leaving DONE by load
        tb_load = 1'b1; tb_load_val = 4'hE;
        tick("ld14");
        check_val("sat_g0", 32'(if_s.gray_out), 32'h9);
        tb_load = 1'b0;
        tick("sat1");
        check_val("sat_g1", 32'(if_s.gray_out), 32'h8);
        tick("sat2");
        check_val("sat_done_valid", 32'(if_s.out_valid), 32'd0);
        check_val("sat_done_tc",    32'(if_s.tc), 32'd1);
        tick("sat3");
        check_val("sat_stay_valid", 32'(if_s.out_valid), 32'd0);
        tb_load = 1'b1; tb_load_val = 4'h3;
        tick("ld3");
        check_val("ld3_gray",  32'(if_s.gray_out), 32'h2);
        check_val("ld3_valid", 32'(if_s.out_valid), 32'd1);

        // Down-count underflow, then load coincident with a transfer
        tb_load_val = 4'h0;
        tick("ld0");
        tb_load = 1'b0; tb_up = 1'b0;
        tick("down");
        check_val("down_bin",  32'(if_w.bin_out), 32'hF);
        check_val("down_gray", 32'(if_w.gray_out), 32'h8);
        tb_load = 1'b1; tb_load_val = 4'hA;
        tick("ld_xfer");
        check_val("ld_xfer_bin", 32'(if_w.bin_out), 32'hA);
        tb_load = 1'b0; tb_up = 1'b1;

        // Reset pulse between clock edges while presenting a code
        tick("pre_rst");
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_all("mid_rst");
        check_val("mid_rst_valid", 32'(if_w.out_valid), 32'd0);
        check_val("mid_rst_gray",  32'(if_w.gray_out), 32'd0);
        #1 rst_n = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            tb_en       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) tb_up = ~tb_up;
            tb_load     = ($urandom_range(0, 15) == 0);
            tb_load_val = 4'($urandom_range(0, 15));
            tb_ready    = ($urandom_range(0, 9) < 7);
            tick("rnd");
        end

`ifdef GRAY_COUNTER_CHECK_EN
        // Corrupted output code must raise a sticky err
        tb_load = 1'b0; tb_en = 1'b1; tb_ready = 1'b0;
        corrupt = 4'(m_cnt[0] ^ (m_cnt[0] / 2)) ^ 4'h1;
        force if_w.gray_out = corrupt;
        @(posedge clk);
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        #1 release if_w.gray_out;
        m_err[0] = 1'b1;
        compare_all("corrupt");
        check_val("corrupt_err", 32'(if_w.err), 32'd1);
        tb_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick("err_held");
        rst_n = 1'b0;
        model_reset();
        #1 compare_all("err_clr");
        rst_n = 1'b1;
`else
        corrupt = 4'h0;
        check_val("final_err", 32'(if_w.err | corrupt[0]), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_gray_counter
